// File: rtl/aer_pkg.sv
// Shared constants for the AER reset blocks.
package aer_pkg;

  // Default width of the reset timer fields (pulse width, period, timeout).
  localparam int unsigned RST_TMR_WIDTH = 16;

endpackage

// File: rtl/aer_reset_monitor.sv
// Observes an active-low AER reset line and measures low-pulse width, the period
// between falling edges and the number of completed pulses. A low pulse longer
// than the timeout raises a sticky error.
module aer_reset_monitor #(
  parameter int unsigned W     = aer_pkg::RST_TMR_WIDTH,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             aer_rst_n_in,
  input  logic [W-1:0]     timeout,
  input  logic             clear,
  output logic [W-1:0]     pulse_width,
  output logic             pulse_valid,
  output logic [W-1:0]     period,
  output logic             period_valid,
  output logic [CNT_W-1:0] pulse_count,
  output logic             stuck_err
);

  typedef enum logic [2:0] {
    StDisabled,
    StArm,
    StHigh,
    StLow,
    StStuck
  } state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     width_cnt_q, width_cnt_d;
  logic [W-1:0]     period_cnt_q, period_cnt_d;
  logic             first_edge_q, first_edge_d;
  logic [W-1:0]     pulse_width_q, pulse_width_d;
  logic             pulse_valid_q, pulse_valid_d;
  logic [W-1:0]     period_q, period_d;
  logic             period_valid_q, period_valid_d;
  logic [CNT_W-1:0] pulse_count_q, pulse_count_d;
  logic             stuck_err_q, stuck_err_d;

  logic             cnt_inc;
  logic             stuck_set;
  logic [W-1:0]     width_sat_inc;
  logic [W-1:0]     period_sat_inc;

  // Saturating increments of the two measurement counters.
  always_comb begin
    width_sat_inc  = (width_cnt_q == '1) ? width_cnt_q : width_cnt_q + W'(1);
    period_sat_inc = (period_cnt_q == '1) ? period_cnt_q : period_cnt_q + W'(1);
  end

  // Next-state logic for the FSM, measurement counters and registered outputs.
  always_comb begin
    state_d        = state_q;
    width_cnt_d    = width_cnt_q;
    period_cnt_d   = period_cnt_q;
    first_edge_d   = first_edge_q;
    pulse_width_d  = pulse_width_q;
    pulse_valid_d  = 1'b0;
    period_d       = period_q;
    period_valid_d = 1'b0;
    pulse_count_d  = pulse_count_q;
    cnt_inc        = 1'b0;
    stuck_set      = 1'b0;

    if (!enable) begin
      // Abandon in-flight measurements; captured outputs keep their values.
      state_d      = StDisabled;
      width_cnt_d  = '0;
      period_cnt_d = '0;
      first_edge_d = 1'b0;
    end else begin
      unique case (state_q)
        StDisabled: begin
          state_d = aer_rst_n_in ? StHigh : StArm;
        end
        StArm: begin
          // A line already low at enable is never counted as a pulse.
          if (aer_rst_n_in) begin
            state_d = StHigh;
          end
        end
        StHigh: begin
          if (!aer_rst_n_in) begin
            state_d      = StLow;
            width_cnt_d  = W'(1);
            period_cnt_d = W'(1);
            first_edge_d = 1'b1;
            if (first_edge_q) begin
              period_d       = period_cnt_q;
              period_valid_d = 1'b1;
            end
          end else begin
            period_cnt_d = period_sat_inc;
          end
        end
        StLow: begin
          period_cnt_d = period_sat_inc;
          if (!aer_rst_n_in) begin
            // Width equal to timeout is still legal; one more low sample is not.
            if ((timeout != '0) && (width_cnt_q == timeout)) begin
              state_d   = StStuck;
              stuck_set = 1'b1;
            end else begin
              width_cnt_d = width_sat_inc;
            end
          end else begin
            state_d       = StHigh;
            pulse_width_d = width_cnt_q;
            pulse_valid_d = 1'b1;
            cnt_inc       = 1'b1;
          end
        end
        StStuck: begin
          // The oversized pulse is dropped, but the period keeps running.
          period_cnt_d = period_sat_inc;
          if (aer_rst_n_in) begin
            state_d = StHigh;
          end
        end
        default: begin
          state_d = StDisabled;
        end
      endcase
    end

    // Clear beats a simultaneous count increment.
    if (clear) begin
      pulse_count_d = '0;
    end else if (cnt_inc && (pulse_count_q != '1)) begin
      pulse_count_d = pulse_count_q + CNT_W'(1);
    end

    // A new error beats a simultaneous clear.
    stuck_err_d = stuck_set | (stuck_err_q & ~clear);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StDisabled;
      width_cnt_q    <= '0;
      period_cnt_q   <= '0;
      first_edge_q   <= 1'b0;
      pulse_width_q  <= '0;
      pulse_valid_q  <= 1'b0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      pulse_count_q  <= '0;
      stuck_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      width_cnt_q    <= width_cnt_d;
      period_cnt_q   <= period_cnt_d;
      first_edge_q   <= first_edge_d;
      pulse_width_q  <= pulse_width_d;
      pulse_valid_q  <= pulse_valid_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      pulse_count_q  <= pulse_count_d;
      stuck_err_q    <= stuck_err_d;
    end
  end

  assign pulse_width  = pulse_width_q;
  assign pulse_valid  = pulse_valid_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign pulse_count  = pulse_count_q;
  assign stuck_err    = stuck_err_q;

endmodule

// File: tb/tb_aer_reset_monitor.sv
// Scoreboard bench for aer_reset_monitor: the driver feeds samples to an
// event-level model that queues expected strobes; a monitor on the falling clock
// edge pops and compares whenever the DUT strobes.
module tb_aer_reset_monitor;

  localparam int unsigned W     = 16;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned WMAX  = (1 << W) - 1;
  localparam int unsigned CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic             aer_line;
  logic [W-1:0]     timeout;
  logic             clear;
  logic [W-1:0]     pulse_width;
  logic             pulse_valid;
  logic [W-1:0]     period;
  logic             period_valid;
  logic [CNT_W-1:0] pulse_count;
  logic             stuck_err;

  always #5 clk = ~clk;

  aer_reset_monitor #(
    .W     (W),
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .aer_rst_n_in (aer_line),
    .timeout      (timeout),
    .clear        (clear),
    .pulse_width  (pulse_width),
    .pulse_valid  (pulse_valid),
    .period       (period),
    .period_valid (period_valid),
    .pulse_count  (pulse_count),
    .stuck_err    (stuck_err)
  );

  int checks   = 0;
  int failures = 0;

  // Expected strobe payloads, in order of the completing sample.
  int unsigned exp_width_q[$];
  int unsigned exp_period_q[$];

  // Event-level model: edges are located by sample index, widths and periods
  // are differences of sample indices.
  int unsigned cyc;
  bit          m_tracking;   // a high sample has been seen since enable
  bit          m_prev_line;
  bit          m_in_pulse;   // inside a low pulse that has not timed out
  int unsigned m_start;
  bit          m_have_fall;
  int unsigned m_last_fall;
  int unsigned m_count;
  bit          m_stuck;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_tracking  = 1'b0;
    m_prev_line = 1'b0;
    m_in_pulse  = 1'b0;
    m_have_fall = 1'b0;
    m_count     = 0;
    m_stuck     = 1'b0;
    exp_width_q.delete();
    exp_period_q.delete();
  endtask

  task automatic model_sample(input bit en, input bit ln, input bit clr, input int unsigned to);
    bit set_stuck;
    bit inc;
    int unsigned d;
    set_stuck = 1'b0;
    inc       = 1'b0;
    cyc++;
    if (!en) begin
      m_tracking  = 1'b0;
      m_in_pulse  = 1'b0;
      m_have_fall = 1'b0;
    end else begin
      if (m_tracking && m_prev_line && !ln) begin
        if (m_have_fall) begin
          d = cyc - m_last_fall;
          exp_period_q.push_back((d > WMAX) ? WMAX : d);
        end
        m_have_fall = 1'b1;
        m_last_fall = cyc;
        m_in_pulse  = 1'b1;
        m_start     = cyc;
      end else if (m_in_pulse && !ln) begin
        if ((to != 0) && (cyc - m_start == to)) begin
          m_in_pulse = 1'b0;
          set_stuck  = 1'b1;
        end
      end else if (m_in_pulse && ln) begin
        d = cyc - m_start;
        exp_width_q.push_back((d > WMAX) ? WMAX : d);
        inc        = 1'b1;
        m_in_pulse = 1'b0;
      end
      if (ln) m_tracking = 1'b1;
      m_prev_line = ln;
    end
    if (clr) m_count = 0;
    else if (inc && m_count < CMAX) m_count++;
    m_stuck = set_stuck | (m_stuck & ~clr);
  endtask

  int unsigned cur_to = 0;

  // One sample: drive on the falling edge, model it at the rising edge.
  task automatic step(input bit en, input bit ln, input bit clr);
    @(negedge clk);
    enable   = en;
    aer_line = ln;
    clear    = clr;
    timeout  = W'(cur_to);
    @(posedge clk);
    model_sample(en, ln, clr, cur_to);
  endtask

  task automatic pulse(input int lo, input int hi);
    for (int i = 0; i < lo; i++) step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < hi; i++) step(1'b1, 1'b1, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pulse_width"}, 32'(pulse_width), 0);
    check({tag, "_pulse_valid"}, 32'(pulse_valid), 0);
    check({tag, "_period"}, 32'(period), 0);
    check({tag, "_period_valid"}, 32'(period_valid), 0);
    check({tag, "_pulse_count"}, 32'(pulse_count), 0);
    check({tag, "_stuck_err"}, 32'(stuck_err), 0);
  endtask

  // Assert reset between clock edges and check the outputs before any edge.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all_zero("async_rst");
    enable = 1'b0;
    clear  = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: every strobe must match a queued expectation, and vice versa.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("pulse_valid", 32'(pulse_valid), 32'(exp_width_q.size() != 0));
      if (exp_width_q.size() != 0) begin
        if (pulse_valid) check("pulse_width", 32'(pulse_width), exp_width_q[0]);
        void'(exp_width_q.pop_front());
      end
      check("period_valid", 32'(period_valid), 32'(exp_period_q.size() != 0));
      if (exp_period_q.size() != 0) begin
        if (period_valid) check("period", 32'(period), exp_period_q[0]);
        void'(exp_period_q.pop_front());
      end
      check("pulse_count", 32'(pulse_count), m_count);
      check("stuck_err", 32'(stuck_err), 32'(m_stuck));
    end
  end

  initial begin
    int  run_left;
    bit  lvl;
    bit  en;
    bit  clr;
    cyc      = 0;
    rst_n    = 1'b0;
    enable   = 1'b0;
    aer_line = 1'b1;
    clear    = 1'b0;
    timeout  = '0;
    model_reset();
    #12;
    check_all_zero("reset");
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    // Single 3-cycle pulse, no period yet.
    repeat (3) step(1'b1, 1'b1, 1'b0);
    pulse(3, 3);

    // Falling edges 10 apart, 2 cycles low each.
    repeat (3) pulse(2, 8);

    // Timeout boundary: width 4 legal, width 5 stuck, then clear.
    cur_to = 4;
    pulse(4, 3);
    pulse(5, 3);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    cur_to = 0;

    // Line low at enable: armed, no pulse until a real falling edge.
    step(1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b1, 1'b0, 1'b0);
    repeat (2) step(1'b1, 1'b1, 1'b0);
    pulse(2, 3);

    // Disable mid-pulse, re-enable with line high.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b1, 1'b0);
    pulse(2, 5);
    pulse(2, 5);

    // Count saturation, then clear coinciding with a completion.
    step(1'b1, 1'b1, 1'b1);
    repeat (260) pulse(1, 1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    repeat (2) step(1'b1, 1'b1, 1'b0);
    pulse(3, 2);

    // Reset asserted in the middle of a low pulse.
    repeat (2) step(1'b1, 1'b0, 1'b0);
    async_reset();
    repeat (2) step(1'b1, 1'b1, 1'b0);
    pulse(2, 4);

    // Randomized traffic.
    run_left = 0;
    lvl      = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) cur_to = $urandom_range(0, 8);
      if (run_left == 0) begin
        lvl      = ~lvl;
        run_left = $urandom_range(1, 10);
      end
      run_left--;
      en  = ($urandom_range(0, 49) != 0);
      clr = ($urandom_range(0, 49) == 0);
      step(en, lvl, clr);
    end
    repeat (3) step(1'b1, 1'b1, 1'b0);

    @(negedge clk);
    #1;
    check("width_queue_drained", 32'(exp_width_q.size()), 0);
    check("period_queue_drained", 32'(exp_period_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
